// File: rtl/writeback_commit_unit_pkg.sv
// Shared X__W message definitions and widths used by the execute units and writeback.
package writeback_commit_unit_pkg;

    localparam int unsigned c_addr_bits     = 32;
    localparam int unsigned c_data_bits     = 32;
    localparam int unsigned c_seq_num_bits  = 5;
    localparam int unsigned c_reg_addr_bits = 5;
    localparam int unsigned c_cnt_bits      = 32;

    typedef struct packed {
        logic [c_addr_bits-1:0]     pc;
        logic [c_seq_num_bits-1:0]  seq_num;
        logic [c_reg_addr_bits-1:0] waddr;
        logic [c_data_bits-1:0]     wdata;
        logic                       wen;
    } t_x__w_msg;

    // x0 is hardwired zero, so writes to it never reach the register file.
    function automatic logic rf_write_ok(input logic wen, input logic [c_reg_addr_bits-1:0] waddr);
        return wen && (waddr != '0);
    endfunction

endpackage

// File: rtl/writeback_commit_unit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanned cyclically from a pointer that moves past each winner.
module rr_arbiter #(
    parameter int unsigned p_width = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_width-1:0] req,
    input  logic               en,
    output logic [p_width-1:0] gnt
);

    localparam int unsigned c_ptr_bits = (p_width > 1) ? $clog2(p_width) : 1;

    logic [c_ptr_bits-1:0] r_ptr;
    logic [c_ptr_bits-1:0] w_ptr_next;
    logic [c_ptr_bits-1:0] w_idx;
    logic                  w_found;

    always_comb begin
        gnt        = '0;
        w_ptr_next = r_ptr;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int unsigned k = 0; k < p_width; k++) begin
            w_idx = c_ptr_bits'((32'(r_ptr) + k) % p_width);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
                w_ptr_next = c_ptr_bits'((32'(w_idx) + 1) % p_width);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && |req) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/writeback_commit_unit.sv
// Writeback stage: arbitrates X__W producers, registers one message per cycle, writes the RF and retires.
module writeback_commit_unit
    import writeback_commit_unit_pkg::*;
#(
    parameter int unsigned p_num_pipes    = 2,
    parameter int unsigned p_addr_bits    = c_addr_bits,
    parameter int unsigned p_data_bits    = c_data_bits,
    parameter int unsigned p_seq_num_bits = c_seq_num_bits,
    parameter int unsigned p_cnt_bits     = c_cnt_bits
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [p_num_pipes-1:0]                 x_val,
    output logic [p_num_pipes-1:0]                 x_rdy,
    input  logic [p_num_pipes*p_addr_bits-1:0]     x_pc,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]  x_seq_num,
    input  logic [p_num_pipes*c_reg_addr_bits-1:0] x_waddr,
    input  logic [p_num_pipes*p_data_bits-1:0]     x_wdata,
    input  logic [p_num_pipes-1:0]                 x_wen,
    output logic                                   rf_wen,
    output logic [c_reg_addr_bits-1:0]             rf_waddr,
    output logic [p_data_bits-1:0]                 rf_wdata,
    output logic                                   cmp_val,
    output logic [p_seq_num_bits-1:0]              cmp_seq_num,
    output logic [p_addr_bits-1:0]                 cmp_pc,
    output logic [p_cnt_bits-1:0]                  retire_cnt
);

    typedef struct packed {
        logic [p_addr_bits-1:0]     pc;
        logic [p_seq_num_bits-1:0]  seq_num;
        logic [c_reg_addr_bits-1:0] waddr;
        logic [p_data_bits-1:0]     wdata;
        logic                       wen;
    } t_stage;

    logic [p_num_pipes-1:0] w_gnt;
    logic                   w_xfer;
    t_stage                 w_cand [p_num_pipes];
    t_stage                 w_acc  [p_num_pipes+1];
    t_stage                 r_stage;
    logic                   r_val;
    logic [p_cnt_bits-1:0]  r_cnt;

    rr_arbiter #(
        .p_width (p_num_pipes)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (x_val),
        .en  (!rst),
        .gnt (w_gnt)
    );

    // Ready is held low while reset is asserted, even though it is combinational.
    assign x_rdy  = rst ? '0 : w_gnt;
    assign w_xfer = |(x_val & x_rdy);

    // One-hot AND-OR mux of the granted producer's message.
    assign w_acc[0] = '0;
    for (genvar gi = 0; gi < p_num_pipes; gi++) begin : g_pipe
        assign w_cand[gi] = w_gnt[gi] ? t_stage'{
            pc:      x_pc[gi*p_addr_bits +: p_addr_bits],
            seq_num: x_seq_num[gi*p_seq_num_bits +: p_seq_num_bits],
            waddr:   x_waddr[gi*c_reg_addr_bits +: c_reg_addr_bits],
            wdata:   x_wdata[gi*p_data_bits +: p_data_bits],
            wen:     x_wen[gi]
        } : '0;
        assign w_acc[gi+1] = t_stage'(w_acc[gi] | w_cand[gi]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= 1'b0;
            r_stage <= '0;
            r_cnt   <= '0;
        end else begin
            r_val <= w_xfer;
            if (w_xfer) begin
                r_stage <= w_acc[p_num_pipes];
            end
            if (r_val) begin
                r_cnt <= r_cnt + p_cnt_bits'(1);
            end
        end
    end

    assign rf_wen      = r_val && rf_write_ok(r_stage.wen, r_stage.waddr);
    assign rf_waddr    = r_stage.waddr;
    assign rf_wdata    = r_stage.wdata;
    assign cmp_val     = r_val;
    assign cmp_seq_num = r_stage.seq_num;
    assign cmp_pc      = r_stage.pc;
    assign retire_cnt  = r_cnt;

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Directed and light random checks of the writeback commit unit (2-pipe/4-bit counter and 1-pipe instances).
module tb_writeback_commit_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  x_val = '0;
    logic [1:0]  x_rdy;
    logic [63:0] x_pc = '0;
    logic [9:0]  x_seq_num = '0;
    logic [9:0]  x_waddr = '0;
    logic [63:0] x_wdata = '0;
    logic [1:0]  x_wen = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        cmp_val;
    logic [4:0]  cmp_seq_num;
    logic [31:0] cmp_pc;
    logic [3:0]  retire_cnt;

    logic        s_x_val = 1'b0;
    logic        s_x_rdy;
    logic [31:0] s_x_pc = '0;
    logic [4:0]  s_x_seq_num = '0;
    logic [4:0]  s_x_waddr = '0;
    logic [31:0] s_x_wdata = '0;
    logic        s_x_wen = 1'b0;
    logic        s_rf_wen;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic        s_cmp_val;
    logic [4:0]  s_cmp_seq_num;
    logic [31:0] s_cmp_pc;
    logic [31:0] s_retire_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_commit_unit #(.p_num_pipes(2), .p_cnt_bits(4)) dut (
        .clk(clk), .rst(rst), .x_val(x_val), .x_rdy(x_rdy), .x_pc(x_pc),
        .x_seq_num(x_seq_num), .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wen(x_wen),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cmp_val(cmp_val),
        .cmp_seq_num(cmp_seq_num), .cmp_pc(cmp_pc), .retire_cnt(retire_cnt)
    );

    writeback_commit_unit #(.p_num_pipes(1)) dut1 (
        .clk(clk), .rst(rst), .x_val(s_x_val), .x_rdy(s_x_rdy), .x_pc(s_x_pc),
        .x_seq_num(s_x_seq_num), .x_waddr(s_x_waddr), .x_wdata(s_x_wdata), .x_wen(s_x_wen),
        .rf_wen(s_rf_wen), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata), .cmp_val(s_cmp_val),
        .cmp_seq_num(s_cmp_seq_num), .cmp_pc(s_cmp_pc), .retire_cnt(s_retire_cnt)
    );

    task automatic drive(input int p, input logic v, input logic [31:0] pc, input logic [4:0] seq,
                         input logic [4:0] wa, input logic [31:0] wd, input logic we);
        x_val[p]           = v;
        x_pc[p*32 +: 32]   = pc;
        x_seq_num[p*5 +: 5] = seq;
        x_waddr[p*5 +: 5]  = wa;
        x_wdata[p*32 +: 32] = wd;
        x_wen[p]           = we;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        x_val   = '0;
        s_x_val = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        x_val = 2'b11;
        s_x_val = 1'b1;
        #1;
        total++; if (x_rdy !== 2'b00) begin bad++; $display("FAIL reset_rdy got=%b exp=00", x_rdy); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
        total++; if (cmp_val !== 1'b0) begin bad++; $display("FAIL reset_cmp_val got=%b exp=0", cmp_val); end
        total++; if (retire_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
        total++; if (s_x_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy1 got=%b exp=0", s_x_rdy); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 1'b1, 32'd0, 5'd0, 5'd1, 32'd2, 1'b1);
        #1;
        total++; if (x_rdy !== 2'b01) begin bad++; $display("FAIL single_rdy got=%b exp=01", x_rdy); end
        tick();
        x_val = '0;
        total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL single_rf_wen got=%b exp=1", rf_wen); end
        total++; if (rf_waddr !== 5'd1) begin bad++; $display("FAIL single_waddr got=%0d exp=1", rf_waddr); end
        total++; if (rf_wdata !== 32'd2) begin bad++; $display("FAIL single_wdata got=%0d exp=2", rf_wdata); end
        total++; if (cmp_val !== 1'b1) begin bad++; $display("FAIL single_cmp_val got=%b exp=1", cmp_val); end
        total++; if (cmp_seq_num !== 5'd0) begin bad++; $display("FAIL single_seq got=%0d exp=0", cmp_seq_num); end
        total++; if (retire_cnt !== 4'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", retire_cnt); end
        tick();
        total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", retire_cnt); end
        total++; if (cmp_val !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", cmp_val); end
    endtask

    task automatic test_back_to_back();
        int i0 = 0;
        int i1 = 0;
        logic [1:0] exp_rdy;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                total++; if (cmp_val !== 1'b1 || cmp_seq_num !== 5'(c) || cmp_pc !== 32'(4*c)) begin
                    bad++; $display("FAIL b2b_cmp cyc=%0d got=%b/%0d/%0d exp=1/%0d/%0d", c, cmp_val, cmp_seq_num, cmp_pc, c, 4*c);
                end
            end
            drive(0, i0 < 3, 32'(4*(2*i0+1)), 5'(2*i0+1), 5'(2*i0+1), 32'(100+2*i0+1), 1'b1);
            drive(1, i1 < 3, 32'(4*(2*i1+2)), 5'(2*i1+2), 5'(2*i1+2), 32'(100+2*i1+2), 1'b1);
            exp_rdy = (c == 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            #1;
            total++; if (x_rdy !== exp_rdy) begin bad++; $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", c, x_rdy, exp_rdy); end
            if (exp_rdy[0]) i0++;
            if (exp_rdy[1]) i1++;
            tick();
        end
        total++; if (cmp_val !== 1'b0 || retire_cnt !== 4'd6) begin
            bad++; $display("FAIL b2b_end got=%b/%0d exp=0/6", cmp_val, retire_cnt);
        end
    endtask

    task automatic test_x0_suppress();
        do_reset();
        drive(1, 1'b1, 32'h40, 5'd7, 5'd0, 32'hDEAD, 1'b1);
        #1;
        total++; if (x_rdy !== 2'b10) begin bad++; $display("FAIL x0_rdy got=%b exp=10", x_rdy); end
        tick();
        total++; if (rf_wen !== 1'b0 || cmp_val !== 1'b1 || cmp_seq_num !== 5'd7) begin
            bad++; $display("FAIL x0_write got=%b/%b/%0d exp=0/1/7", rf_wen, cmp_val, cmp_seq_num);
        end
        drive(1, 1'b1, 32'h44, 5'd8, 5'd7, 32'h1234, 1'b0);
        tick();
        x_val = '0;
        total++; if (rf_wen !== 1'b0 || cmp_val !== 1'b1 || cmp_seq_num !== 5'd8) begin
            bad++; $display("FAIL nowen_write got=%b/%b/%0d exp=0/1/8", rf_wen, cmp_val, cmp_seq_num);
        end
        tick();
        total++; if (retire_cnt !== 4'd2) begin bad++; $display("FAIL x0_cnt got=%0d exp=2", retire_cnt); end
    endtask

    task automatic test_ptr();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 32'(k*4), 5'(10+k), 5'd3, 32'(k), 1'b1);
            #1;
            total++; if (x_rdy !== 2'b10) begin bad++; $display("FAIL ptr_solo k=%0d got=%b exp=10", k, x_rdy); end
            tick();
        end
        drive(0, 1'b1, 32'h200, 5'd20, 5'd4, 32'd5, 1'b1);
        drive(1, 1'b1, 32'h300, 5'd13, 5'd3, 32'd6, 1'b1);
        #1;
        total++; if (x_rdy !== 2'b01) begin bad++; $display("FAIL ptr_contend got=%b exp=01", x_rdy); end
        tick();
        x_val[0] = 1'b0;
        total++; if (cmp_seq_num !== 5'd20) begin bad++; $display("FAIL ptr_first got=%0d exp=20", cmp_seq_num); end
        #1;
        total++; if (x_rdy !== 2'b10) begin bad++; $display("FAIL ptr_second_rdy got=%b exp=10", x_rdy); end
        tick();
        x_val = '0;
        total++; if (cmp_seq_num !== 5'd13) begin bad++; $display("FAIL ptr_second got=%0d exp=13", cmp_seq_num); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1'b1, 32'h80, 5'd3, 5'd2, 32'd30, 1'b1);
        tick();
        drive(0, 1'b1, 32'h84, 5'd4, 5'd2, 32'd40, 1'b1);
        tick();
        total++; if (cmp_val !== 1'b1 || retire_cnt !== 4'd1) begin
            bad++; $display("FAIL arst_pre got=%b/%0d exp=1/1", cmp_val, retire_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (cmp_val !== 1'b0 || rf_wen !== 1'b0 || x_rdy !== 2'b00 || retire_cnt !== 4'd0) begin
            bad++; $display("FAIL arst_now got=%b/%b/%b/%0d exp=0/0/00/0", cmp_val, rf_wen, x_rdy, retire_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        total++; if (x_rdy !== 2'b01) begin bad++; $display("FAIL arst_rdy got=%b exp=01", x_rdy); end
        tick();
        x_val = '0;
        total++; if (cmp_val !== 1'b1 || cmp_seq_num !== 5'd4 || rf_wen !== 1'b1 || rf_wdata !== 32'd40) begin
            bad++; $display("FAIL arst_resend got=%b/%0d/%b/%0d exp=1/4/1/40", cmp_val, cmp_seq_num, rf_wen, rf_wdata);
        end
        tick();
        total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL arst_cnt got=%0d exp=1", retire_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(0, 1'b1, 32'(k*4), 5'(k), 5'(k % 31 + 1), 32'(k), 1'b1);
            tick();
        end
        x_val = '0;
        total++; if (retire_cnt !== 4'd0 || cmp_val !== 1'b1) begin
            bad++; $display("FAIL wrap16 got=%0d/%b exp=0/1", retire_cnt, cmp_val);
        end
        tick();
        total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL wrap17 got=%0d exp=1", retire_cnt); end
    endtask

    task automatic test_single_pipe();
        do_reset();
        s_x_val = 1'b1; s_x_pc = 32'h90; s_x_seq_num = 5'd9; s_x_waddr = 5'd5; s_x_wdata = 32'd77; s_x_wen = 1'b1;
        #1;
        total++; if (s_x_rdy !== 1'b1) begin bad++; $display("FAIL p1_rdy got=%b exp=1", s_x_rdy); end
        tick();
        s_x_val = 1'b0;
        total++; if (s_cmp_val !== 1'b1 || s_cmp_seq_num !== 5'd9 || s_rf_wdata !== 32'd77) begin
            bad++; $display("FAIL p1_cmp got=%b/%0d/%0d exp=1/9/77", s_cmp_val, s_cmp_seq_num, s_rf_wdata);
        end
        #1;
        total++; if (s_x_rdy !== 1'b0) begin bad++; $display("FAIL p1_idle got=%b exp=0", s_x_rdy); end
    endtask

    task automatic test_random();
        logic       pend [2];
        int         dly  [2];
        logic [4:0] mseq [2];
        int         gen = 0;
        int         done = 0;
        int         cyc = 0;
        int         mp = 0;
        int         g;
        int         idx;
        logic       exp_v = 1'b0;
        logic [4:0] exp_seq = '0;
        logic [1:0] exp_rdy;
        pend[0] = 1'b0; pend[1] = 1'b0;
        dly[0] = 1; dly[1] = 0;
        mseq[0] = '0; mseq[1] = '0;
        do_reset();
        while (done < 20 && cyc < 200) begin
            total++; if (cmp_val !== exp_v || (exp_v && (cmp_seq_num !== exp_seq || cmp_pc !== 32'h1000 + 32'(exp_seq)*4))) begin
                bad++; $display("FAIL rand_cmp cyc=%0d got=%b/%0d exp=%b/%0d", cyc, cmp_val, cmp_seq_num, exp_v, exp_seq);
            end
            if (exp_v) done++;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if (dly[p] == 0 && gen < 20) begin
                        pend[p] = 1'b1; mseq[p] = 5'(gen); gen++;
                    end else if (dly[p] > 0) begin
                        dly[p]--;
                    end
                end
                drive(p, pend[p], 32'h1000 + 32'(mseq[p])*4, mseq[p], 5'd9, 32'(mseq[p]), 1'b1);
            end
            g = -1;
            for (int k = 0; k < 2; k++) begin
                idx = (mp + k) % 2;
                if (g < 0 && pend[idx]) g = idx;
            end
            exp_rdy = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
            #1;
            total++; if (x_rdy !== exp_rdy) begin bad++; $display("FAIL rand_rdy cyc=%0d got=%b exp=%b", cyc, x_rdy, exp_rdy); end
            if (g >= 0) begin
                exp_v = 1'b1; exp_seq = mseq[g]; pend[g] = 1'b0;
                dly[g] = int'($urandom_range(0, 2)); mp = (g + 1) % 2;
            end else begin
                exp_v = 1'b0;
            end
            tick();
            cyc++;
        end
        x_val = '0;
        total++; if (done != 20) begin bad++; $display("FAIL rand_timeout got=%0d exp=20", done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_x0_suppress();
        test_ptr();
        test_async_reset();
        test_wrap();
        test_single_pipe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_commit_unit.md
Name: writeback_commit_unit

Overview:
Writeback stage: the receiving end of the X__W val/rdy interface driven by the execute units (ALU, multiplier, etc.).
- Round-robin arbitrates among p_num_pipes X__W producers.
- Registers one winning message per cycle, then writes the register file and reports completion (seq_num) to the scoreboard/in-flight tracker.
- Keeps a running retired-instruction count.

Parameters:
p_num_pipes, 2, number of X__W producers arbitrated (>=1)
p_addr_bits, 32, pc width
p_data_bits, 32, register data width
p_seq_num_bits, 5, sequence-number width
p_cnt_bits, 32, retired-instruction counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
x_val  input  p_num_pipes  per-producer message valid
x_rdy  output  p_num_pipes  per-producer ready (one-hot or zero)
x_pc  input  p_num_pipes*p_addr_bits  per-producer pc
x_seq_num  input  p_num_pipes*p_seq_num_bits  per-producer seq_num
x_waddr  input  p_num_pipes*5  per-producer destination register
x_wdata  input  p_num_pipes*p_data_bits  per-producer write data
x_wen  input  p_num_pipes  per-producer write enable
rf_wen  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  p_data_bits  register-file write data
cmp_val  output  1  completion valid (one instruction retired this cycle)
cmp_seq_num  output  p_seq_num_bits  retired instruction seq_num
cmp_pc  output  p_addr_bits  retired instruction pc
retire_cnt  output  p_cnt_bits  total instructions retired since reset

Behaviour:
- Reset is asynchronous: on rst high, clear stage valid, priority pointer and retire_cnt to 0 immediately.
  - All outputs read 0 during reset, including x_rdy, rf_wen and cmp_val.
- Handshake: a transfer on producer i occurs on a rising edge with x_val[i] & x_rdy[i].
  - x_rdy may depend combinationally on x_val; producers must not derive x_val from x_rdy.
- Arbitration:
  - grant = first i with x_val[i] set, scanning cyclically from ptr (ptr, ptr+1, ..., wrapping mod p_num_pipes).
  - x_rdy = grant. The stage drains every cycle, so no downstream backpressure exists.
  - No valid inputs: x_rdy = 0 and ptr holds.
  - On a transfer from i: ptr <= (i+1) mod p_num_pipes.
  - Starvation bound: a persistently valid producer is granted within p_num_pipes cycles.
- Stage register: on a transfer, capture pc/seq_num/waddr/wdata/wen and set stage valid. With no transfer, stage valid <= 0.
- Latency: exactly 1 cycle from the accepting edge to rf_wen/cmp_val high. Throughput is 1 message per cycle.
- Outputs driven from the stage register only:
  - rf_wen = stage_val & wen & (waddr != 0). A write to x0 is suppressed but still completes.
  - cmp_val = stage_val, regardless of wen.
  - rf_waddr, rf_wdata, cmp_seq_num, cmp_pc = stage fields. They are don't-care when stage valid is 0 but must be driven (no X).
- retire_cnt increments by 1 on every cycle cmp_val is high and wraps from 2^p_cnt_bits-1 to 0.
- Simultaneous valids from all producers: exactly one is accepted per cycle. The others hold val and data stable until accepted.
- Reset mid-stream: an in-flight stage entry is discarded with no rf write and no completion. Producers re-present after reset.
- p_num_pipes=1: degenerates to x_rdy = x_val and ptr stays 0.

Decomposition:
- UArch package gains typedef t_x__w_msg (pc, seq_num, waddr, wdata, wen), parameterised by width localparams shared with execute units.
- One sub-module: rr_arbiter (parameter p_width; inputs req, en; output one-hot gnt; internal pointer updated on en & |req). Reused by future issue logic.

Test Plan:
- Single producer 0 sends pc=0, seq=0, waddr=1, wdata=2, wen=1 -> next cycle rf_wen=1, rf_waddr=1, rf_wdata=2, cmp_val=1, cmp_seq_num=0; retire_cnt goes 0->1.
- Both producers valid continuously from reset (p0: seq 1,3,5; p1: seq 2,4,6) -> accept order p0,p1,p0,p1,p0,p1; cmp_seq_num 1,2,3,4,5,6 on consecutive cycles; non-granted x_rdy=0 each cycle.
- Producer 1 sends waddr=0, wdata=0xDEAD, wen=1; then waddr=7, wen=0 -> both give rf_wen=0 and cmp_val=1; retire_cnt increments twice.
- Only p1 valid for 3 cycles, then both valid -> ptr after p1 grants is 0, so p0 is granted first in the contended cycle.
- Assert rst asynchronously (mid-cycle) while a stage entry is valid -> cmp_val, rf_wen, x_rdy and retire_cnt go 0 immediately. After release, the resent entry completes normally.
- p_cnt_bits=4: retire 17 messages -> retire_cnt wraps to 1. Also a 20-iteration random run with delays on val, checking every accepted message appears exactly once on completion, in accept order.
